// File: rtl/linear_mac.sv
// rtl/linear_mac.sv - sequential fixed-point linear layer (y = x*W + b) using one multiplier and one accumulator
module linear_mac #(
    parameter int INPUT_SIZE  = 4,
    parameter int OUTPUT_SIZE = 4,
    parameter int COUNT       = 1,
    parameter int DATA_W      = 32,
    parameter int FRAC_BITS   = 16,
    parameter int ACC_W       = 2*DATA_W + $clog2(INPUT_SIZE) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     relu_en,
    input  logic signed [DATA_W-1:0] data_in  [COUNT][INPUT_SIZE],
    input  logic signed [DATA_W-1:0] weights  [INPUT_SIZE][OUTPUT_SIZE],
    input  logic signed [DATA_W-1:0] biases   [COUNT][OUTPUT_SIZE],
    output logic signed [DATA_W-1:0] data_out [COUNT][OUTPUT_SIZE],
    output logic                     busy,
    output logic                     done
);

    localparam int IW = (INPUT_SIZE  > 1) ? $clog2(INPUT_SIZE)  : 1;
    localparam int OW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam int RW = (COUNT       > 1) ? $clog2(COUNT)       : 1;

    localparam logic [IW-1:0] I_LAST = IW'(INPUT_SIZE - 1);
    localparam logic [OW-1:0] O_LAST = OW'(OUTPUT_SIZE - 1);
    localparam logic [RW-1:0] R_LAST = RW'(COUNT - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                    r_state;
    logic [IW-1:0]             r_i;
    logic [OW-1:0]             r_o;
    logic [RW-1:0]             r_r;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_relu;
    logic                      r_busy;
    logic                      r_done;
    logic signed [DATA_W-1:0]  r_snap_in [COUNT][INPUT_SIZE];
    logic signed [DATA_W-1:0]  r_snap_w  [INPUT_SIZE][OUTPUT_SIZE];
    logic signed [DATA_W-1:0]  r_snap_b  [COUNT][OUTPUT_SIZE];
    logic signed [DATA_W-1:0]  r_out     [COUNT][OUTPUT_SIZE];

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_shift;
    logic signed [DATA_W-1:0]   w_sat;
    logic signed [DATA_W-1:0]   w_result;
    logic                       w_last_o;
    logic                       w_last_r;
    logic [OW-1:0]              w_next_o;
    logic [RW-1:0]              w_next_r;

    // Bias enters the accumulator already aligned to the product's 2*FRAC_BITS scale.
    function automatic logic signed [ACC_W-1:0] bias_ext(input logic signed [DATA_W-1:0] b);
        logic signed [ACC_W-1:0] t;
        t = ACC_W'(b);
        return t <<< FRAC_BITS;
    endfunction

    assign w_prod   = r_snap_in[r_r][r_i] * r_snap_w[r_i][r_o];
    assign w_shift  = r_acc >>> FRAC_BITS;
    assign w_last_o = (r_o == O_LAST);
    assign w_last_r = (r_r == R_LAST);
    assign w_next_o = w_last_o ? '0 : r_o + 1'b1;
    // Row index stays put on the final entry so the bias lookup never leaves the array.
    assign w_next_r = (w_last_o && !w_last_r) ? r_r + 1'b1 : r_r;

    always_comb begin
        w_sat = w_shift[DATA_W-1:0];
        if (w_shift > SAT_MAX) begin
            w_sat = SAT_MAX[DATA_W-1:0];
        end else if (w_shift < SAT_MIN) begin
            w_sat = SAT_MIN[DATA_W-1:0];
        end
        w_result = (r_relu && w_sat[DATA_W-1]) ? '0 : w_sat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_o     <= '0;
            r_r     <= '0;
            r_acc   <= '0;
            r_relu  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int r = 0; r < COUNT; r++) begin
                for (int o = 0; o < OUTPUT_SIZE; o++) begin
                    r_out[r][o] <= '0;
                end
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_snap_in <= data_in;
                        r_snap_w  <= weights;
                        r_snap_b  <= biases;
                        r_relu    <= relu_en;
                        r_i       <= '0;
                        r_o       <= '0;
                        r_r       <= '0;
                        r_acc     <= bias_ext(biases[0][0]);
                        r_busy    <= 1'b1;
                        r_state   <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (!enable) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= r_acc + ACC_W'(w_prod);
                        if (r_i == I_LAST) begin
                            r_state <= S_WRITE;
                        end else begin
                            r_i <= r_i + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (!enable) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_out[r_r][r_o] <= w_result;
                        r_o   <= w_next_o;
                        r_r   <= w_next_r;
                        r_i   <= '0;
                        r_acc <= bias_ext(r_snap_b[w_next_r][w_next_o]);
                        if (w_last_o && w_last_r) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_MAC;
                        end
                    end
                end
                S_DONE: begin
                    if (!enable) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_out = r_out;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: doc/linear_mac.md
LINEAR_MAC -- requirements
Module: linear_mac

Interface
REQ-001 SHALL have parameter INPUT_SIZE, default 4, meaning input features per row.
REQ-002 SHALL have parameter OUTPUT_SIZE, default 4, meaning output features per row.
REQ-003 SHALL have parameter COUNT, default 1, meaning rows (batch) per operation.
REQ-004 SHALL have parameter DATA_W, default 32, meaning signed fixed-point word width.
REQ-005 SHALL have parameter FRAC_BITS, default 16, meaning fractional bits of every word.
REQ-006 SHALL have parameter ACC_W, default 2*DATA_W+$clog2(INPUT_SIZE)+1, meaning accumulator width.
REQ-007 clk  in  1  single clock; all state updates on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 enable  in  1  level request; high starts/holds operation, low aborts or clears done.
REQ-010 relu_en  in  1  when high, negative results are written as 0.
REQ-011 data_in  in  [DATA_W] x [COUNT][INPUT_SIZE]  input activations, signed.
REQ-012 weights  in  [DATA_W] x [INPUT_SIZE][OUTPUT_SIZE]  weight matrix, signed.
REQ-013 biases  in  [DATA_W] x [COUNT][OUTPUT_SIZE]  bias values, signed.
REQ-014 data_out  out  [DATA_W] x [COUNT][OUTPUT_SIZE]  registered results.
REQ-015 busy  out  1  high while in MAC or WRITE.
REQ-016 done  out  1  high while in DONE.

Function
REQ-017 SHALL compute data_out[r][o] = sum_i data_in[r][i]*weights[i][o] + biases[r][o], for every r, o.
REQ-018 SHALL implement states IDLE, MAC, WRITE, DONE using one multiplier and one accumulator.
REQ-019 IDLE, enable=1 at edge E0: snapshot data_in, weights, biases, relu_en; r=o=i=0; acc=sign-extended biases[0][0]<<<FRAC_BITS; go to MAC.
REQ-020 MAC: each edge acc += snap_in[r][i]*snap_w[i][o] at full precision; i increments; after the edge with i=INPUT_SIZE-1, go to WRITE.
REQ-021 WRITE: one edge; data_out[r][o] = acc>>>FRAC_BITS (arithmetic shift, floor), saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1], then 0 if relu_en snapshot=1 and value negative.
REQ-022 WRITE: advance o, wrapping to 0 and incrementing r at OUTPUT_SIZE-1; reload acc with the next bias<<<FRAC_BITS; i=0; go to MAC, or to DONE after r=COUNT-1, o=OUTPUT_SIZE-1.
REQ-023 done SHALL rise exactly COUNT*OUTPUT_SIZE*(INPUT_SIZE+1) edges after E0.
REQ-024 DONE: hold data_out and done while enable=1; on edge with enable=0 go to IDLE, done=0.
REQ-025 Input changes after E0 SHALL NOT affect the running operation (snapshot only).
REQ-026 enable=0 sampled in MAC or WRITE SHALL abort to IDLE next edge; done stays 0; entries already written keep values, unwritten ones keep prior values.
REQ-027 enable held high in IDLE after abort/DONE exit restarts only via IDLE sampling enable=1 (one idle edge minimum between operations).
REQ-028 Accumulator SHALL NOT overflow for any inputs given ACC_W default; saturation applies only at WRITE.
REQ-029 busy and done SHALL never be high simultaneously.

Reset
REQ-030 rst=1 at an edge SHALL force IDLE, done=0, busy=0, all data_out=0, counters and acc=0, regardless of state; rst has priority over enable.
REQ-031 After rst deasserts with enable=1, operation SHALL start at the first edge sampling rst=0.

Verification (IN=2, OUT=2, COUNT=1, DATA_W=32, FRAC_BITS=16 unless stated)
REQ-032 x=[1.0,2.0], W=[[1.0,0.5],[3.0,-1.0]], b=[0.5,0], relu_en=0 -> data_out=[0x00078000, 0xFFFE8000], done high exactly 6 edges after E0, busy high for those 6 cycles.
REQ-033 Same stimulus, relu_en=1 -> data_out=[0x00078000, 0x00000000].
REQ-034 x=[30000.0,0], W[0][0]=30000.0, b=0 -> data_out[0][0]=0x7FFFFFFF; negate x -> 0x80000000.
REQ-035 Drop enable on 4th edge after E0 -> IDLE next edge, done never rises, data_out[0][0]=0x00078000, data_out[0][1] unchanged.
REQ-036 COUNT=2, change data_in right after E0 -> results match snapshot values; done at edge E0+12.
REQ-037 rst pulse in MAC -> next edge all outputs 0, IDLE; re-enable yields correct results from REQ-032.
